// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for VGA 640x480@60 (geometry is parameterised).
// A horizontal counter (DrawX) and a vertical counter (DrawY) advance on the
// pixel-enable strobe. The design decodes the visible-region flag and both
// syncs from the counters, then delays them through a short shift register.
// This keeps them aligned with the downstream sprite/palette pipeline, which
// registers colour a fixed number of pixel ticks after it sees DrawX/DrawY.
//
// Ports
//   vga_clk      in   system clock, all state on its rising edge
//   Reset        in   synchronous, active-high reset (priority over pix_en)
//   pix_en       in   pixel tick; counters and delay line move only when 1
//   DrawX        out  horizontal counter, 0..H_TOTAL-1
//   DrawY        out  vertical counter, 0..V_TOTAL-1
//   blank        out  1 = visible pixel, 0 = blanking (delayed PIPE_DELAY ticks)
//   hs           out  horizontal sync, asserted level SYNC_ACTIVE (delayed)
//   vs           out  vertical sync, asserted level SYNC_ACTIVE (delayed)
//   line_start   out  one-clock pulse on the pixel tick where DrawX == 0
//   frame_start  out  one-clock pulse on the pixel tick where DrawX == DrawY == 0
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter int unsigned PIPE_DELAY  = 1
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start
);

    // ------------------------------------------------------------------
    // Derived geometry, pre-sized to the 10-bit counter width so every
    // compare below is between equal-width operands.
    // ------------------------------------------------------------------
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    // One delay-line entry: the three signals that must stay aligned with
    // the renderer pipeline travel together.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_t;

    // Value every delay stage is flushed to on reset: syncs idle, not visible.
    localparam sync_t SYNC_IDLE = '{hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE, blank: 1'b0};

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;

    // NOTE: combinational blocks assign every output a default first, so no
    // path through the block leaves a variable unassigned and no latch forms.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (pix_en) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                // The line wrap is the only event that moves the vertical counter.
                if (vc_q == V_LAST) begin
                    vc_d = '0;
                end else begin
                    vc_d = vc_q + 10'd1;
                end
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign DrawX = hc_q;
    assign DrawY = vc_q;

    // ------------------------------------------------------------------
    // Raw decode of the current counter position
    // ------------------------------------------------------------------
    sync_t sync_raw;

    always_comb begin
        sync_raw       = SYNC_IDLE;
        sync_raw.blank = (hc_q < H_VIS_END) && (vc_q < V_VIS_END);
        sync_raw.hs    = ((hc_q >= HS_START) && (hc_q < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        sync_raw.vs    = ((vc_q >= VS_START) && (vc_q < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    // ------------------------------------------------------------------
    // Alignment delay line. It steps on pixel ticks, not clocks, so the
    // lag measured in pixels is the same whatever the pix_en duty cycle.
    // ------------------------------------------------------------------
    sync_t sync_out;

    if (PIPE_DELAY == 0) begin : g_no_pipe
        assign sync_out = sync_raw;
    end else begin : g_pipe
        sync_t pipe_q [PIPE_DELAY];

        // Reset flushes every stage so an in-progress sync pulse cannot
        // drain out after a mid-frame restart.
        always_ff @(posedge vga_clk) begin
            if (Reset) begin
                for (int i = 0; i < PIPE_DELAY; i++) begin
                    pipe_q[i] <= SYNC_IDLE;
                end
            end else if (pix_en) begin
                pipe_q[0] <= sync_raw;
                for (int i = 1; i < PIPE_DELAY; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign sync_out = pipe_q[PIPE_DELAY-1];
    end

    assign blank = sync_out.blank;
    assign hs    = sync_out.hs;
    assign vs    = sync_out.vs;

    // ------------------------------------------------------------------
    // Strobes: combinational from registered state, qualified by pix_en so
    // they last one clock even when the pixel clock is a divided strobe.
    // ------------------------------------------------------------------
    assign line_start  = pix_en && (hc_q == 10'd0);
    assign frame_start = pix_en && (hc_q == 10'd0) && (vc_q == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Five instances share one clock/reset/pix_en:
//   d0, d1, d2 : full 640x480 geometry with PIPE_DELAY 0, 1, 2
//   s0, s1     : reduced 8x6 geometry (4+1+2+1 by 3+1+1+1) with PIPE_DELAY 0, 1
// The reduced geometry lets whole frames, the (last,last) wrap and the
// half-rate strobe run in a few hundred cycles.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge, where the combinational strobes reflect current pix_en.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic pen;

    logic [9:0] d0_x, d0_y, d1_x, d1_y, d2_x, d2_y, s0_x, s0_y, s1_x, s1_y;
    logic d0_b, d0_h, d0_v, d0_ls, d0_fs;
    logic d1_b, d1_h, d1_v, d1_ls, d1_fs;
    logic d2_b, d2_h, d2_v, d2_ls, d2_fs;
    logic s0_b, s0_h, s0_v, s0_ls, s0_fs;
    logic s1_b, s1_h, s1_v, s1_ls, s1_fs;

    vga_timing_gen #(.PIPE_DELAY(0)) u_d0 (
        .vga_clk(clk), .Reset(rst), .pix_en(pen), .DrawX(d0_x), .DrawY(d0_y),
        .blank(d0_b), .hs(d0_h), .vs(d0_v), .line_start(d0_ls), .frame_start(d0_fs));

    vga_timing_gen #(.PIPE_DELAY(1)) u_d1 (
        .vga_clk(clk), .Reset(rst), .pix_en(pen), .DrawX(d1_x), .DrawY(d1_y),
        .blank(d1_b), .hs(d1_h), .vs(d1_v), .line_start(d1_ls), .frame_start(d1_fs));

    vga_timing_gen #(.PIPE_DELAY(2)) u_d2 (
        .vga_clk(clk), .Reset(rst), .pix_en(pen), .DrawX(d2_x), .DrawY(d2_y),
        .blank(d2_b), .hs(d2_h), .vs(d2_v), .line_start(d2_ls), .frame_start(d2_fs));

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE_DELAY(0)
    ) u_s0 (
        .vga_clk(clk), .Reset(rst), .pix_en(pen), .DrawX(s0_x), .DrawY(s0_y),
        .blank(s0_b), .hs(s0_h), .vs(s0_v), .line_start(s0_ls), .frame_start(s0_fs));

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE_DELAY(1)
    ) u_s1 (
        .vga_clk(clk), .Reset(rst), .pix_en(pen), .DrawX(s1_x), .DrawY(s1_y),
        .blank(s1_b), .hs(s1_h), .vs(s1_v), .line_start(s1_ls), .frame_start(s1_fs));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference raster position, advanced once per pixel tick.
    task automatic adv(inout int x, inout int y, input int ht, input int vt);
        if (x == ht - 1) begin
            x = 0;
            y = (y == vt - 1) ? 0 : y + 1;
        end else begin
            x = x + 1;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Table vectors for the reduced PIPE_DELAY=1 instance (s1).
    typedef struct {
        logic       rst;
        logic       pen;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       ls;
        logic       fs;
    } vec_t;

    vec_t tbl [20];

    task automatic set_vec(input int i, input logic r, input logic p, input int x, input int y,
                           input logic h, input logic v, input logic b, input logic l, input logic f);
        tbl[i].rst = r;  tbl[i].pen = p;
        tbl[i].x = 10'(x); tbl[i].y = 10'(y);
        tbl[i].hs = h; tbl[i].vs = v; tbl[i].blank = b; tbl[i].ls = l; tbl[i].fs = f;
    endtask

    initial begin
        int ex, ey;
        int pos_err, hs_err, vs_err, blank_err, per_err, pulse_err;
        int ls_n, fs_n, last_ls, last_fs, vs_low;
        logic prev_ls, prev_fs, wrap_pending;

        //          i  rst pen  x  y  hs vs bl ls fs
        set_vec( 0, 1, 1, 0, 0, 1, 1, 0, 1, 1);  // in reset: idle pipe, strobes follow pix_en
        set_vec( 1, 0, 1, 0, 0, 1, 1, 0, 1, 1);  // first tick after release
        set_vec( 2, 0, 1, 1, 0, 1, 1, 1, 0, 0);  // blank lags by one tick
        set_vec( 3, 0, 0, 2, 0, 1, 1, 1, 0, 0);  // pix_en=0: hold, no strobe
        set_vec( 4, 0, 0, 2, 0, 1, 1, 1, 0, 0);
        set_vec( 5, 0, 1, 2, 0, 1, 1, 1, 0, 0);
        set_vec( 6, 0, 1, 3, 0, 1, 1, 1, 0, 0);
        set_vec( 7, 0, 1, 4, 0, 1, 1, 1, 0, 0);  // still shows raw blank of x=3
        set_vec( 8, 0, 1, 5, 0, 1, 1, 0, 0, 0);  // blank falls one tick after last visible
        set_vec( 9, 0, 1, 6, 0, 0, 1, 0, 0, 0);  // hs asserted (raw x=5)
        set_vec(10, 0, 1, 7, 0, 0, 1, 0, 0, 0);
        set_vec(11, 0, 1, 0, 1, 1, 1, 0, 1, 0);  // line wrap: line_start only
        set_vec(12, 0, 1, 1, 1, 1, 1, 1, 0, 0);
        set_vec(13, 0, 1, 2, 1, 1, 1, 1, 0, 0);
        set_vec(14, 0, 1, 3, 1, 1, 1, 1, 0, 0);
        set_vec(15, 0, 1, 4, 1, 1, 1, 1, 0, 0);
        set_vec(16, 0, 1, 5, 1, 1, 1, 0, 0, 0);
        set_vec(17, 1, 1, 6, 1, 0, 1, 0, 0, 0);  // reset while hs is asserted
        set_vec(18, 0, 1, 0, 0, 1, 1, 0, 1, 1);  // restart at (0,0), flushed pipe
        set_vec(19, 0, 1, 1, 0, 1, 1, 1, 0, 0);

        // ---------------- reset held three cycles ----------------
        rst = 1'b1;
        pen = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        check("d0_reset", {d0_x, d0_y, d0_h, d0_v, d0_b, d0_ls, d0_fs}, {10'd0, 10'd0, 5'b11111});
        check("d1_reset", {d1_x, d1_y, d1_h, d1_v, d1_b, d1_ls, d1_fs}, {10'd0, 10'd0, 5'b11011});
        check("d2_reset", {d2_x, d2_y, d2_h, d2_v, d2_b, d2_ls, d2_fs}, {10'd0, 10'd0, 5'b11011});
        next_cycle();

        // ---------------- table vectors ----------------
        for (int i = 0; i < 20; i++) begin
            rst = tbl[i].rst;
            pen = tbl[i].pen;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {s1_x, s1_y, s1_h, s1_v, s1_b, s1_ls, s1_fs},
                  {tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].blank, tbl[i].ls, tbl[i].fs});
            if (i == 1) begin
                check("d1_first_strobes", {d1_ls, d1_fs}, 2'b11);
            end
            next_cycle();
        end

        // ---------------- full-size horizontal scan ----------------
        rst = 1'b1; pen = 1'b1;
        next_cycle();
        rst = 1'b0;
        ex = 0; ey = 0;
        pos_err = 0; hs_err = 0; blank_err = 0; per_err = 0;
        ls_n = 0; fs_n = 0; last_ls = -1;
        for (int c = 0; c < 1700; c++) begin
            @(negedge clk);
            if (d0_x !== 10'(ex) || d0_y !== 10'(ey)) pos_err++;
            if (d0_h !== ((ex >= 656 && ex <= 751) ? 1'b0 : 1'b1)) hs_err++;
            if (d0_b !== ((ex < 640 && ey < 480) ? 1'b1 : 1'b0)) blank_err++;
            if (d0_ls === 1'b1) begin
                if (last_ls >= 0 && c - last_ls != 800) per_err++;
                last_ls = c;
                ls_n++;
            end
            if (d0_fs === 1'b1) fs_n++;
            if (ex == 640) check("d1_blank_at_640", d1_b, 1);
            if (ex == 641) check("d1_blank_at_641", d1_b, 0);
            if (ex == 641) check("d2_blank_at_641", d2_b, 1);
            if (ex == 642) check("d2_blank_at_642", d2_b, 0);
            if (ex == 657) check("d2_hs_at_657", d2_h, 1);
            if (ex == 658) check("d2_hs_at_658", d2_h, 0);
            if (ex == 753) check("d2_hs_at_753", d2_h, 0);
            if (ex == 754) check("d2_hs_at_754", d2_h, 1);
            next_cycle();
            adv(ex, ey, 800, 525);
        end
        check("h_position_errors", pos_err, 0);
        check("h_hs_window_errors", hs_err, 0);
        check("h_blank_window_errors", blank_err, 0);
        check("h_line_period_errors", per_err, 0);
        check("h_line_start_count", ls_n, 3);
        check("h_frame_start_count", fs_n, 1);

        // ---------------- reduced-geometry full frames ----------------
        rst = 1'b1; pen = 1'b1;
        next_cycle();
        rst = 1'b0;
        ex = 0; ey = 0;
        pos_err = 0; vs_err = 0; blank_err = 0; per_err = 0;
        fs_n = 0; last_fs = -1; vs_low = 0; wrap_pending = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (s0_x !== 10'(ex) || s0_y !== 10'(ey)) pos_err++;
            if (s0_v !== ((ey == 4) ? 1'b0 : 1'b1)) vs_err++;
            if (s0_v === 1'b0) vs_low++;
            if (s0_b !== ((ex < 4 && ey < 3) ? 1'b1 : 1'b0)) blank_err++;
            if (s0_fs === 1'b1) begin
                if (last_fs >= 0 && c - last_fs != 48) per_err++;
                last_fs = c;
                fs_n++;
            end
            if (wrap_pending) begin
                check("v_wrap_to_origin", {s0_x, s0_y}, 20'd0);
                wrap_pending = 1'b0;
            end
            if (ex == 7 && ey == 5) wrap_pending = 1'b1;
            next_cycle();
            adv(ex, ey, 8, 6);
        end
        check("v_position_errors", pos_err, 0);
        check("v_vs_window_errors", vs_err, 0);
        check("v_vs_low_ticks", vs_low, 24);
        check("v_blank_window_errors", blank_err, 0);
        check("v_frame_period_errors", per_err, 0);
        check("v_frame_start_count", fs_n, 4);

        // ---------------- half-rate pixel strobe ----------------
        rst = 1'b1; pen = 1'b1;
        next_cycle();
        rst = 1'b0;
        ex = 0; ey = 0;
        pos_err = 0; per_err = 0; pulse_err = 0;
        fs_n = 0; last_fs = -1; prev_ls = 1'b0; prev_fs = 1'b0;
        for (int c = 0; c < 200; c++) begin
            pen = (c % 2 == 0);
            @(negedge clk);
            if (s0_x !== 10'(ex) || s0_y !== 10'(ey)) pos_err++;
            if (s0_fs === 1'b1) begin
                if (last_fs >= 0 && c - last_fs != 96) per_err++;
                last_fs = c;
                fs_n++;
            end
            if ((s0_ls && prev_ls) || (s0_fs && prev_fs)) pulse_err++;
            if ((s0_ls || s0_fs) && !pen) pulse_err++;
            prev_ls = s0_ls;
            prev_fs = s0_fs;
            next_cycle();
            if (pen) adv(ex, ey, 8, 6);
        end
        check("half_position_errors", pos_err, 0);
        check("half_frame_period_errors", per_err, 0);
        check("half_pulse_width_errors", pulse_err, 0);
        check("half_frame_start_count", fs_n, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA 640x480@60 raster timing: pixel coordinates (DrawX, DrawY), visible-region flag (blank), and horizontal/vertical sync.
- Drives the sprite/palette renderers, which consume DrawX, DrawY and blank and register colour on vga_clk.
- Delays sync and blank by a programmable number of pixel ticks so they stay aligned with the renderers' ROM/palette pipeline.
- Advances on a pixel-enable strobe, so it runs either on a true 25 MHz clock or on a faster clock with a divide strobe.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_ACTIVE, 0, asserted level of hs and vs
- PIPE_DELAY, 1, pixel ticks of delay applied to hs, vs and blank (0 to 4)

Ports:
- vga_clk  input  1  system clock; all logic is on its rising edge
- Reset  input  1  synchronous, active-high reset
- pix_en  input  1  pixel tick; counters and the delay line advance only when it is 1
- DrawX  output  10  horizontal counter hc, 0..H_TOTAL-1
- DrawY  output  10  vertical counter vc, 0..V_TOTAL-1
- blank  output  1  1 = visible pixel (draw), 0 = blanking interval
- hs  output  1  horizontal sync, level set by SYNC_ACTIVE
- vs  output  1  vertical sync, level set by SYNC_ACTIVE
- line_start  output  1  one-vga_clk pulse at the start of each line
- frame_start  output  1  one-vga_clk pulse at the start of each frame

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 800.
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP = 525.
  - All counters are 10 bits unsigned.
- Counters:
  - When pix_en=1: hc increments, wrapping H_TOTAL-1 -> 0.
  - vc increments only on that hc wrap, wrapping V_TOTAL-1 -> 0.
  - When pix_en=0: hc and vc hold.
  - DrawX = hc and DrawY = vc, both registered and presented throughout blanking.
- Raw decode from current hc/vc:
  - blank_raw = (hc < H_ACTIVE) and (vc < V_ACTIVE).
  - hs_raw asserted for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, i.e. hc 656..751.
  - vs_raw asserted for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, i.e. vc 490..491.
- Delay line:
  - hs, vs and blank are the raw decodes delayed through a PIPE_DELAY-stage shift register.
  - The shift register shifts only when pix_en=1.
  - PIPE_DELAY=0 makes them combinational decodes of the registered counters.
- Strobes:
  - line_start = pix_en and (hc == 0).
  - frame_start = pix_en and (hc == 0) and (vc == 0).
  - Both are combinational from registered state and high for exactly one vga_clk per qualifying tick.
- Reset (synchronous, has priority over pix_en):
  - hc = vc = 0, so DrawX = DrawY = 0.
  - Every delay stage is loaded with hs = vs = ~SYNC_ACTIVE and blank = 0.
  - With PIPE_DELAY=0, blank reads 1 during reset because (0,0) is visible.
- Reset mid-frame: the next cycle restarts at (0,0) with no partial sync pulse carried forward beyond the flushed delay line.
- First tick after reset release with pix_en=1: frame_start and line_start both pulse.
- Wrap at (799,524) with pix_en=1: the next state is (0,0) in one step; vc never reaches 525 and hc never reaches 800.
- Delayed outputs lag DrawX/DrawY by exactly PIPE_DELAY pixel ticks. Example: with PIPE_DELAY=1, blank falls on the tick after DrawX=639.

Test Plan:
- Reset check: hold Reset 3 cycles with pix_en=1 -> DrawX=0, DrawY=0, hs=1, vs=1, blank=0 (PIPE_DELAY=1, SYNC_ACTIVE=0); the first tick after release gives frame_start=1 and line_start=1.
- Horizontal timing, pix_en tied 1, PIPE_DELAY=0:
  - line_start repeats every 800 cycles.
  - hs=0 exactly when DrawX is 656..751.
  - blank=1 exactly when DrawX is 0..639 on lines 0..479.
- Vertical timing: run a full frame -> frame_start every 420000 cycles; vs=0 exactly for DrawY 490..491 (1600 ticks); blank=0 for all of DrawY 480..524; DrawY wraps 524 -> 0 together with DrawX 799 -> 0.
- Half-rate: pix_en toggles 1,0,1,0 -> counters hold on pix_en=0 cycles, the frame takes 840000 cycles, and each strobe is a single-cycle pulse.
- PIPE_DELAY=2: blank falls 2 ticks after DrawX=639 (when DrawX=641); hs falls when DrawX=658 and rises when DrawX=754.
- Reset mid-frame: assert Reset at DrawX=700, DrawY=300 while hs is asserted -> the next cycle shows DrawX=0, DrawY=0, hs=1, and no stale sync or blank emerges from the delay line.
